// File: rtl/entry_pkg.sv
// Shared definitions for the entry-gate authentication stage: key codes,
// PIN geometry and the controller state encoding.
package entry_pkg;
  localparam int PIN_DIGITS = 4;
  localparam int PIN_W      = 4 * PIN_DIGITS;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef enum logic [2:0] {
    IDLE,
    GET_FLAT,
    GET_PIN,
    CHECK,
    REPORT,
    LOCKED
  } state_t;
endpackage

// File: rtl/pwd_table.sv
// Per-flat PIN store: async read, sync write, out-of-range writes dropped.
module pwd_table
  import entry_pkg::*;
#(
  parameter int N  = 16,
  parameter int FW = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [FW-1:0]    wr_addr,
  input  logic [PIN_W-1:0] wr_data,
  input  logic [FW-1:0]    rd_addr,
  output logic [PIN_W-1:0] rd_data
);
  logic [PIN_W-1:0] mem [0:N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= N; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr <= FW'(N))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (rd_addr <= FW'(N)) ? mem[rd_addr] : '0;
endmodule

// File: rtl/entry_auth_fsm.sv
// Keypad entry controller: collects flat number and PIN, checks against the
// password table, reports one auth_valid pulse per attempt, locks out on repeated failures.
module entry_auth_fsm
  import entry_pkg::*;
#(
  parameter int N              = 16,
  parameter int FW             = $clog2(N) + 1,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             pwd_wr_en,
  input  logic [FW-1:0]    pwd_wr_addr,
  input  logic [PIN_W-1:0] pwd_wr_data,
  output logic [FW-1:0]    flat_number,
  output logic             pwd_flag,
  output logic             auth_valid,
  output logic             locked,
  output logic             busy
);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W  = $clog2(PIN_DIGITS + 1);

  state_t            state, nxt;
  logic [FW-1:0]     acc, acc_base, acc_step;
  logic [FW+3:0]     acc_wide;
  logic [PIN_W-1:0]  pin, tbl_pin;
  logic [CNT_W-1:0]  dcnt;
  logic [FAIL_W-1:0] fails;
  logic [LOCK_W-1:0] lock_tmr;
  logic [TO_W-1:0]   to_tmr;

  logic is_digit, is_enter, is_clear, in_session, timed_out, lock_done;
  logic flat_bad, pin_full, pin_ok;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_enter   = key_valid && (key_code == KEY_ENTER);
  assign is_clear   = key_valid && (key_code == KEY_CLEAR);
  assign in_session = (state == GET_FLAT) || (state == GET_PIN);
  assign timed_out  = in_session && !key_valid && (to_tmr == TO_W'(TIMEOUT_CYCLES - 1));
  assign lock_done  = lock_tmr == LOCK_W'(LOCK_CYCLES - 1);
  assign flat_bad   = acc > FW'(N);
  assign pin_full   = dcnt == CNT_W'(PIN_DIGITS);
  assign pin_ok     = pin == tbl_pin;

  // Decimal accumulate; anything past N saturates at N+1 so it stays invalid.
  assign acc_base = (state == IDLE) ? '0 : acc;
  assign acc_wide = (FW+4)'(acc_base) * (FW+4)'(10) + (FW+4)'(key_code);
  assign acc_step = (acc_wide > (FW+4)'(N)) ? FW'(N + 1) : acc_wide[FW-1:0];

  // Async read means CHECK sees the pre-write value on a same-cycle write.
  pwd_table #(.N(N), .FW(FW)) u_tbl (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pwd_wr_en),
    .wr_addr (pwd_wr_addr),
    .wr_data (pwd_wr_data),
    .rd_addr (acc),
    .rd_data (tbl_pin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    auth_valid = 1'b0;
    locked     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:     if (is_digit) nxt = GET_FLAT;
      GET_FLAT: begin
        if (is_clear || timed_out) nxt = IDLE;
        else if (is_enter)         nxt = flat_bad ? REPORT : GET_PIN;
      end
      GET_PIN: begin
        if (is_clear || timed_out) nxt = IDLE;
        else if (is_enter)         nxt = pin_full ? CHECK : REPORT;
      end
      CHECK:    nxt = REPORT;
      REPORT: begin
        auth_valid = 1'b1;
        nxt        = (fails == FAIL_W'(MAX_TRIES)) ? LOCKED : IDLE;
      end
      LOCKED: begin
        locked = 1'b1;
        if (lock_done) nxt = IDLE;
      end
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      pin         <= '0;
      dcnt        <= '0;
      fails       <= '0;
      lock_tmr    <= '0;
      to_tmr      <= '0;
      flat_number <= '0;
      pwd_flag    <= 1'b0;
    end else begin
      to_tmr   <= (in_session && !key_valid && !timed_out) ? to_tmr + TO_W'(1) : '0;
      lock_tmr <= (state == LOCKED && !lock_done) ? lock_tmr + LOCK_W'(1) : '0;
      case (state)
        IDLE: begin
          acc  <= is_digit ? acc_step : '0;
          pin  <= '0;
          dcnt <= '0;
        end
        GET_FLAT: begin
          if (is_digit) acc <= acc_step;
          else if (is_enter && flat_bad) begin
            fails       <= fails + FAIL_W'(1);
            pwd_flag    <= 1'b0;
            flat_number <= acc;
          end
        end
        GET_PIN: begin
          if (is_digit) begin
            if (!pin_full) begin
              pin  <= {pin[PIN_W-5:0], key_code};
              dcnt <= dcnt + CNT_W'(1);
            end
          end else if (is_enter && !pin_full) begin
            fails       <= fails + FAIL_W'(1);
            pwd_flag    <= 1'b0;
            flat_number <= acc;
          end
        end
        CHECK: begin
          pwd_flag    <= pin_ok;
          fails       <= pin_ok ? '0 : fails + FAIL_W'(1);
          flat_number <= acc;
        end
        LOCKED:  if (lock_done) fails <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_entry_auth_fsm.sv
// Bench for entry_auth_fsm: directed scenarios plus randomized sessions,
// checked against a session-level model of the keypad rules.
module tb_entry_auth_fsm;
  localparam int N           = 16;
  localparam int FW          = 5;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 1000;
  localparam int TIMEOUT     = 5000;

  logic          clk, rst_n;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          pwd_wr_en;
  logic [FW-1:0] pwd_wr_addr;
  logic [15:0]   pwd_wr_data;
  logic [FW-1:0] flat_number;
  logic          pwd_flag, auth_valid, locked, busy;

  entry_auth_fsm #(.N(N), .FW(FW), .MAX_TRIES(MAX_TRIES),
                   .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .pwd_wr_en(pwd_wr_en), .pwd_wr_addr(pwd_wr_addr), .pwd_wr_data(pwd_wr_data),
    .flat_number(flat_number), .pwd_flag(pwd_flag), .auth_valid(auth_valid),
    .locked(locked), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  int auth_cnt = 0;
  bit prev_av = 1'b0;

  // Reference model state
  int m_tbl [0:N];
  int m_fails = 0;
  int fq[$];
  int pq[$];

  always @(negedge clk) begin
    if (auth_valid) begin
      auth_cnt++;
      checks++;
      if (prev_av) begin
        errs++;
        $display("FAIL auth_pulse_width: auth_valid high 2 cycles in a row, want 1");
      end
    end
    prev_av = auth_valid;
  end

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    pwd_wr_en = 1'b1; pwd_wr_addr = FW'(a); pwd_wr_data = d;
    @(posedge clk); #1;
    pwd_wr_en = 1'b0;
    if (a <= N) m_tbl[a] = int'(d);
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    while (n < LOCK_CYCLES + 200) begin
      @(negedge clk);
      if (!locked) break;
      n++;
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 4'($urandom_range(0, 15));
    end
    key_valid = 1'b0; key_code = 4'h0;
    checks++;
    if (n != LOCK_CYCLES) begin
      errs++; $display("FAIL lock_length: locked for %0d cycles, want %0d", n, LOCK_CYCLES);
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL post_lock_idle: busy=%b, want 0", busy);
    end
    m_fails = 0;
  endtask

  // Drives fq (flat digits) and pq (PIN digits), predicts and checks the report.
  task automatic run_entry(input bit wr_chk, input logic [15:0] wr_val);
    int f, pv, lat, n;
    bit exp_flag;
    f = 0;
    foreach (fq[i]) begin press(4'(fq[i])); gap(); f = f * 10 + fq[i]; end
    press(4'hA);
    if (f > N) begin
      exp_flag = 1'b0; lat = 1;
    end else begin
      foreach (pq[i]) begin gap(); press(4'(pq[i])); end
      gap(); press(4'hA);
      pv = 0;
      for (int i = 0; i < 4 && i < pq.size(); i++) pv = pv * 16 + pq[i];
      exp_flag = (pq.size() >= 4) && (pv == m_tbl[f]);
      lat = (pq.size() >= 4) ? 2 : 1;
    end
    if (wr_chk && lat == 2) begin
      pwd_wr_en = 1'b1; pwd_wr_addr = FW'(f); pwd_wr_data = wr_val;
      fork begin @(posedge clk); #1 pwd_wr_en = 1'b0; end join_none
      m_tbl[f] = int'(wr_val);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!auth_valid && n < 8);
    checks++;
    if (n != lat || auth_valid !== 1'b1) begin
      errs++; $display("FAIL auth_latency: %0d cycles (valid=%b), want %0d", n, auth_valid, lat);
    end
    checks++;
    if (pwd_flag !== exp_flag) begin
      errs++; $display("FAIL pwd_flag flat=%0d: got %b, want %b", f, pwd_flag, exp_flag);
    end
    if (f <= N) begin
      checks++;
      if (flat_number !== FW'(f)) begin
        errs++; $display("FAIL flat_number: got %0d, want %0d", flat_number, f);
      end
    end
    m_fails = exp_flag ? 0 : m_fails + 1;
    if (m_fails == MAX_TRIES) wait_lock();
    else begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || locked !== 1'b0) begin
        errs++; $display("FAIL back_to_idle: busy=%b locked=%b, want 0 0", busy, locked);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    pwd_wr_en = 1'b0; pwd_wr_addr = '0; pwd_wr_data = '0;
    for (int i = 0; i <= N; i++) m_tbl[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({flat_number, pwd_flag, auth_valid, locked, busy} !== '0) begin
      errs++; $display("FAIL reset_outputs: got flat=%0d flag=%b av=%b lk=%b busy=%b, want all 0",
                       flat_number, pwd_flag, auth_valid, locked, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    wr(5, 16'h1234);
    fq = {5}; pq = {1, 2, 3, 4};
    run_entry(1'b0, 16'h0);
  endtask

  task automatic test_lockout();
    fq = {5}; pq = {1, 2, 3, 5};
    repeat (3) run_entry(1'b0, 16'h0);
  endtask

  task automatic test_bad_flat();
    // Invalid flat must count as one failure: two short PINs then lock.
    fq = {9, 9}; pq = {};
    run_entry(1'b0, 16'h0);
    fq = {5}; pq = {1, 2};
    run_entry(1'b0, 16'h0);
    fq = {1, 6}; pq = {7};
    run_entry(1'b0, 16'h0);
  endtask

  task automatic test_clear();
    int a0;
    a0 = auth_cnt;
    press(4'd5); press(4'hA); press(4'd1); press(4'd2); press(4'hB);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL clear_busy: got %b, want 0", busy); end
    repeat (5) @(negedge clk);
    checks++;
    if (auth_cnt != a0) begin errs++; $display("FAIL clear_no_auth: got %0d pulses, want 0", auth_cnt - a0); end
    fq = {5}; pq = {1, 2, 3, 4};
    run_entry(1'b0, 16'h0);
  endtask

  task automatic test_timeout();
    int a0;
    a0 = auth_cnt;
    press(4'd5); press(4'hA);
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL timeout_early: busy=%b, want 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL timeout_idle: busy=%b, want 0", busy); end
    checks++;
    if (auth_cnt != a0) begin errs++; $display("FAIL timeout_no_auth: got %0d pulses, want 0", auth_cnt - a0); end
    #1;
  endtask

  task automatic test_write_in_check();
    wr(7, 16'h4321);
    fq = {7}; pq = {4, 3, 2, 1};
    run_entry(1'b1, 16'h8765);
    fq = {7}; pq = {8, 7, 6, 5};
    run_entry(1'b0, 16'h0);
  endtask

  task automatic test_random();
    int f, r, v;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = 0;
        for (int k = 0; k < 4; k++) v = v * 16 + int'($urandom_range(0, 9));
        wr(int'($urandom_range(0, 31)), 16'(v));
      end
      f = int'($urandom_range(0, 20));
      if (f >= 10)                       fq = {f / 10, f % 10};
      else if ($urandom_range(0, 1) == 1) fq = {0, f};
      else                               fq = {f};
      pq = {};
      if (f <= N && $urandom_range(0, 1) == 1)
        for (int k = 3; k >= 0; k--) pq.push_back((m_tbl[f] >> (4 * k)) & 15);
      else
        for (int k = 0; k < 4; k++) pq.push_back(int'($urandom_range(0, 9)));
      r = int'($urandom_range(0, 5));
      if (r == 0)      void'(pq.pop_back());
      else if (r == 1) pq.push_back(int'($urandom_range(0, 9)));
      run_entry(1'b0, 16'h0);
    end
  endtask

  task automatic test_reset_mid();
    press(4'd5); press(4'hA); press(4'd1); press(4'd2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({flat_number, pwd_flag, auth_valid, locked, busy} !== '0) begin
      errs++; $display("FAIL reset_mid_outputs: got flat=%0d flag=%b av=%b lk=%b busy=%b, want all 0",
                       flat_number, pwd_flag, auth_valid, locked, busy);
    end
    for (int i = 0; i <= N; i++) m_tbl[i] = 0;
    m_fails = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fq = {5}; pq = {0, 0, 0, 0};
    run_entry(1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_lockout();
    test_bad_flat();
    test_clear();
    test_timeout();
    test_write_in_check();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - errs, checks);
    $finish;
  end
endmodule

// File: doc/entry_auth_fsm.md
Name: entry_auth_fsm

Overview:
Entry-gate authentication stage that sits directly upstream of the slot-availability stage. It collects a flat number and a 4-digit PIN from the gate keypad and checks the PIN against a programmable per-flat password table. It then presents pwd_flag and flat_number to the slot-availability stage with a one-cycle auth_valid strobe. Repeated failures trigger a timed lockout.

Parameters:
N, 16 (codebase default `parking_slots), highest flat index; valid flat numbers are 0..N.
FW, $clog2(N)+1, width of flat_number, matching the slot-availability input.
PIN_DIGITS, 4, BCD digits per PIN; the table word width is 4*PIN_DIGITS.
MAX_TRIES, 3, consecutive failures before lockout.
LOCK_CYCLES, 1000, lockout duration in clk cycles.
TIMEOUT_CYCLES, 5000, keypad inactivity limit before the session is abandoned.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe; key_code is valid in that cycle
key_code  in  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, others ignored
pwd_wr_en  in  1  write strobe for the admin password table
pwd_wr_addr  in  FW  flat index to write
pwd_wr_data  in  4*PIN_DIGITS  BCD PIN to store
flat_number  out  FW  registered flat index of the last check
pwd_flag  out  1  1 = PIN matched; meaningful when auth_valid is high
auth_valid  out  1  one-cycle pulse per completed check
locked  out  1  high during lockout
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - flat_number=0, pwd_flag=0, auth_valid=0, locked=0, busy=0.
  - Fail counter, lock timer, timeout timer, digit accumulators and digit count all clear to 0.
  - Every password table entry clears to 0.
- States: IDLE, GET_FLAT, GET_PIN, CHECK, REPORT, LOCKED.
- IDLE:
  - A digit key moves to GET_FLAT and loads the flat accumulator with that digit.
  - ENTER, CLEAR and unused codes are ignored.
- GET_FLAT:
  - Each digit updates acc = acc*10 + d. Once acc exceeds N it is pinned at N+1, the "invalid" value.
  - ENTER with acc<=N moves to GET_PIN.
  - ENTER with acc>N counts as a failed attempt and goes to REPORT with pwd_flag=0.
- GET_PIN:
  - Digits shift into the PIN register as the LSB nibble.
  - A 5th or later digit is ignored.
  - ENTER with exactly PIN_DIGITS digits entered moves to CHECK. ENTER with fewer digits is a failed attempt and goes to REPORT with pwd_flag=0.
- CHECK (1 cycle):
  - Compare the entered PIN with table[flat].
  - On match, pwd_flag=1 and the fail counter clears.
  - On mismatch, pwd_flag=0 and the fail counter increments.
- REPORT (1 cycle):
  - auth_valid=1 and flat_number is updated.
  - Next state is LOCKED if fail counter == MAX_TRIES, otherwise IDLE.
  - Total latency from the final ENTER to auth_valid is 2 cycles (1 cycle on the flat-invalid or short-PIN paths).
- LOCKED:
  - locked=1 and all keys are ignored.
  - After LOCK_CYCLES cycles: go to IDLE, clear the fail counter, drop locked.
- CLEAR in GET_FLAT or GET_PIN: return to IDLE, discard accumulators, no auth_valid, fail counter unchanged.
- Inactivity timeout:
  - In GET_FLAT or GET_PIN, a timer counts cycles without key_valid and restarts on any key.
  - At TIMEOUT_CYCLES it behaves exactly like CLEAR.
- Table writes:
  - Accepted in any state; the write takes effect next cycle.
  - A write in the same cycle as CHECK to the same address: CHECK uses the old value.
  - Writes with pwd_wr_addr>N are dropped.
- Outputs are held between reports. auth_valid never stays high for more than 1 cycle.
- A key_valid arriving during CHECK, REPORT or LOCKED is dropped.

Decomposition:
- Shared package entry_pkg holds:
  - key code constants KEY_ENTER=4'hA, KEY_CLEAR=4'hB;
  - the state enum;
  - PIN_DIGITS and the PIN word width.
- One sub-module, pwd_table: (N+1) x 4*PIN_DIGITS register file with asynchronous read, synchronous write, async reset to 0, and a write address range guard.

Test Plan:
- Write table[5]=16'h1234; keys 5, ENTER, 1, 2, 3, 4, ENTER -> 2 cycles after the last ENTER: auth_valid=1, pwd_flag=1, flat_number=5.
- Same sequence with PIN 1,2,3,5 three times -> three auth_valid pulses with pwd_flag=0; locked=1 after the third; keys ignored for 1000 cycles; then locked=0 and the fail counter is 0.
- Keys 9, 9, ENTER with N=16 -> auth_valid=1, pwd_flag=0, fail counter=1; no GET_PIN entered.
- Keys 5, ENTER, 1, 2, CLEAR -> busy falls to 0 next cycle, no auth_valid; a subsequent correct sequence passes.
- Keys 5, ENTER, then 5000 idle cycles -> IDLE, busy=0, no auth_valid.
- rst_n low mid GET_PIN -> all outputs 0 immediately and table[5] reads 0; a subsequent entry of 0000 for flat 5 gives pwd_flag=1.
